// File: rtl/peripheral_bus_pkg.sv
// Shared types and default constants for the peripheral bus arbiter.
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        XFER    = 2'd2
    } bus_state_t;

    localparam int DEF_NUM_MASTERS   = 16;
    localparam int DEF_START_TIMEOUT = 4;
    localparam int DEF_WAIT_TIMEOUT  = 16;

    // Index width that stays legal for a single-master build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peripheral_rr_picker.sv
// Combinational round-robin picker: first requester after last_winner, wrapping.
module peripheral_rr_picker
    import peripheral_bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IW-1:0]          last_winner,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IW-1:0]          index,
    output logic                   valid
);

    logic [IW-1:0] cand;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = '0;
        // Offset NUM_MASTERS lands back on last_winner, so it is tried last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IW'((int'(last_winner) + k) % NUM_MASTERS);
            if (!valid && request[cand]) begin
                valid        = 1'b1;
                index        = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin bus arbiter with start timeout, wait timeout and registered grant.
module peripheral_bus_arbiter
    import peripheral_bus_pkg::*;
#(
    parameter int NUM_MASTERS   = DEF_NUM_MASTERS,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int WAIT_TIMEOUT  = DEF_WAIT_TIMEOUT
) (
    input  logic                                  sig_clock,
    input  logic                                  sig_reset,
    input  logic [NUM_MASTERS-1:0]                sig_request,
    input  logic                                  sig_start,
    input  logic                                  sig_bip,
    input  logic                                  sig_wait,
    output logic [NUM_MASTERS-1:0]                sig_grant,
    output logic [idx_width(NUM_MASTERS)-1:0]     grant_id,
    output logic                                  sig_error
);

    localparam int IW  = idx_width(NUM_MASTERS);
    localparam int SCW = $clog2(START_TIMEOUT + 1);
    localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

    bus_state_t             state, state_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [IW-1:0]          id_n;
    logic [IW-1:0]          last_winner, last_winner_n;
    logic [SCW-1:0]         start_cnt, start_cnt_n;
    logic [WCW-1:0]         wait_cnt, wait_cnt_n;
    logic                   error_n;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   owner_req;

    peripheral_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_picker (
        .request     (sig_request),
        .last_winner (last_winner),
        .winner      (pick_onehot),
        .index       (pick_idx),
        .valid       (pick_valid)
    );

    assign owner_req = sig_request[grant_id];

    always_ff @(posedge sig_clock) begin
        if (!sig_reset) begin
            state       <= IDLE;
            sig_grant   <= '0;
            grant_id    <= '0;
            sig_error   <= 1'b0;
            start_cnt   <= '0;
            wait_cnt    <= '0;
            last_winner <= IW'(NUM_MASTERS - 1);
        end else begin
            state       <= state_n;
            sig_grant   <= grant_n;
            grant_id    <= id_n;
            sig_error   <= error_n;
            start_cnt   <= start_cnt_n;
            wait_cnt    <= wait_cnt_n;
            last_winner <= last_winner_n;
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = sig_grant;
        id_n          = grant_id;
        last_winner_n = last_winner;
        start_cnt_n   = start_cnt;
        wait_cnt_n    = wait_cnt;
        error_n       = 1'b0;

        unique case (state)
            IDLE: begin
                // Grant is low for this whole cycle, giving the turnaround gap.
                grant_n     = '0;
                id_n        = '0;
                start_cnt_n = '0;
                wait_cnt_n  = '0;
                if (pick_valid) begin
                    grant_n       = pick_onehot;
                    id_n          = pick_idx;
                    last_winner_n = pick_idx;
                    state_n       = GRANTED;
                end
            end
            GRANTED: begin
                if (sig_start) begin
                    state_n    = XFER;
                    wait_cnt_n = '0;
                end else if (!owner_req || start_cnt == SCW'(START_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    grant_n = '0;
                    id_n    = '0;
                end else begin
                    start_cnt_n = start_cnt + 1'b1;
                end
            end
            XFER: begin
                if (!sig_wait) begin
                    wait_cnt_n = '0;
                    if (!sig_bip) begin
                        state_n = IDLE;
                        grant_n = '0;
                        id_n    = '0;
                    end
                end else if (wait_cnt == WCW'(WAIT_TIMEOUT - 1)) begin
                    wait_cnt_n = WCW'(WAIT_TIMEOUT);
                    error_n    = 1'b1;
                    state_n    = IDLE;
                    grant_n    = '0;
                    id_n       = '0;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                id_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed scenarios plus randomized traffic against a tenure-level reference model.
module tb_peripheral_bus_arbiter;

    localparam int NM = 16;
    localparam int ST = 4;
    localparam int WT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] req;
    logic          start, bip, wt;
    logic [NM-1:0] sig_grant;
    logic [3:0]    grant_id;
    logic          sig_error;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the bus and how far into the tenure it is.
    int m_owner;
    int m_last;
    bit m_xfer;
    int m_nostart;
    int m_wait;
    bit m_err;

    always #5 clk = ~clk;

    peripheral_bus_arbiter #(
        .NUM_MASTERS   (NM),
        .START_TIMEOUT (ST),
        .WAIT_TIMEOUT  (WT)
    ) dut (
        .sig_clock   (clk),
        .sig_reset   (rst),
        .sig_request (req),
        .sig_start   (start),
        .sig_bip     (bip),
        .sig_wait    (wt),
        .sig_grant   (sig_grant),
        .grant_id    (grant_id),
        .sig_error   (sig_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (!rst) begin
            m_owner = -1; m_last = NM - 1; m_xfer = 0; m_nostart = 0; m_wait = 0;
            return;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (m_last + k) % NM;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_last = c;
                end
            end
            m_xfer = 0; m_nostart = 0; m_wait = 0;
        end else if (!m_xfer) begin
            if (start) begin
                m_xfer = 1; m_wait = 0;
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_nostart++;
                if (m_nostart == ST) m_owner = -1;
            end
        end else begin
            if (!wt) begin
                m_wait = 0;
                if (!bip) m_owner = -1;
            end else begin
                m_wait++;
                if (m_wait == WT) begin
                    m_err = 1'b1; m_owner = -1;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [NM-1:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", 32'(sig_grant), 32'(eg));
        chk("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("error", 32'(sig_error), 32'(m_err));
        chk("onehot", 32'($countones(sig_grant) <= 1), 32'd1);
    endtask

    task automatic idle_inputs();
        req = '0; start = 0; bip = 0; wt = 0;
    endtask

    initial begin
        logic [NM-1:0] seq[$];
        logic [NM-1:0] prev;
        int wait_pct;

        rst = 0; idle_inputs();
        cycle(); cycle();
        chk("reset_grant", 32'(sig_grant), 32'd0);
        chk("reset_id", 32'(grant_id), 32'd0);
        rst = 1;

        // Single transfer by master 0.
        req = 16'h0001;
        cycle();
        chk("s1_grant", 32'(sig_grant), 32'h0001);
        start = 1;
        cycle();
        start = 0; wt = 0; bip = 0; req = '0;
        cycle();
        chk("s1_release", 32'(sig_grant), 32'd0);
        cycle();

        // Two requesters alternate; fresh reset so master 0 goes first.
        rst = 0; cycle(); rst = 1;
        req = 16'h8001; prev = '0;
        for (int i = 0; i < 14; i++) begin
            start = (m_owner >= 0 && !m_xfer);
            cycle();
            if (sig_grant != prev && sig_grant != '0) seq.push_back(sig_grant);
            prev = sig_grant;
        end
        chk("alt_count", 32'(seq.size() >= 3), 32'd1);
        if (seq.size() >= 3) begin
            chk("alt_0", 32'(seq[0]), 32'h0001);
            chk("alt_1", 32'(seq[1]), 32'h8000);
            chk("alt_2", 32'(seq[2]), 32'h0001);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();

        // Burst with mid-burst stall; request dropped before the last phase.
        req = 16'h0001;
        cycle();
        start = 1; bip = 1;
        cycle();
        start = 0;
        cycle();
        wt = 1; cycle(); cycle();
        wt = 0; cycle();
        chk("burst_held", 32'(sig_grant), 32'h0001);
        bip = 0; req = '0;
        cycle();
        chk("burst_release", 32'(sig_grant), 32'd0);
        cycle();

        // Master 3 never starts; master 5 takes over after the turnaround cycle.
        req = 16'h0028;
        cycle();
        chk("to_grant3", 32'(sig_grant), 32'h0008);
        cycle(); cycle(); cycle();
        cycle();
        chk("to_release", 32'(sig_grant), 32'd0);
        cycle();
        chk("to_grant5", 32'(sig_grant), 32'h0020);
        req = '0;
        cycle(); cycle();

        // Wait timeout.
        req = 16'h0001;
        cycle();
        start = 1;
        cycle();
        start = 0; bip = 1; wt = 1; req = '0;
        for (int i = 0; i < WT - 1; i++) cycle();
        chk("wto_no_err", 32'(sig_error), 32'd0);
        cycle();
        chk("wto_err", 32'(sig_error), 32'd1);
        chk("wto_release", 32'(sig_grant), 32'd0);
        wt = 0; bip = 0;
        cycle();
        chk("wto_pulse_end", 32'(sig_error), 32'd0);

        // Reset in the middle of a burst.
        req = 16'h0004;
        cycle();
        start = 1; bip = 1;
        cycle();
        start = 0; wt = 0;
        cycle();
        rst = 0; wt = 1;
        cycle();
        chk("rst_grant", 32'(sig_grant), 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_err", 32'(sig_error), 32'd0);
        rst = 1; wt = 0; bip = 0;
        cycle();
        chk("rst_regrant", 32'(sig_grant), 32'h0004);
        req = '0;
        cycle(); cycle();

        // Randomized traffic.
        wait_pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) wait_pct = ($urandom_range(0, 1) == 1) ? 97 : 30;
            rst   = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) req = NM'($urandom & $urandom);
            start = ($urandom_range(0, 9) < 4);
            bip   = $urandom_range(0, 1) == 1;
            wt    = ($urandom_range(0, 99) < wait_pct);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_arbiter.md
PERIPHERAL_BUS_ARBITER -- requirements
Module: peripheral_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 16, number of requesters.
REQ-002 SHALL have parameter START_TIMEOUT, default 4, cycles a granted master has to assert sig_start.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 16, maximum consecutive sig_wait cycles per data phase.
REQ-004 SHALL have port sig_clock  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port sig_reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sig_request  input  NUM_MASTERS  per-master bus request.
REQ-007 SHALL have port sig_start  input  1  owner starts a transfer (address phase).
REQ-008 SHALL have port sig_bip  input  1  burst in progress; more data phases follow.
REQ-009 SHALL have port sig_wait  input  1  slave stall; data phase not complete.
REQ-010 SHALL have port sig_grant  output  NUM_MASTERS  one-hot-or-zero grant, registered.
REQ-011 SHALL have port grant_id  output  clog2(NUM_MASTERS)  index of current owner; 0 when no grant.
REQ-012 SHALL have port sig_error  output  1  one-cycle pulse on wait timeout.

Function
REQ-013 SHALL implement FSM states IDLE, GRANTED, XFER.
REQ-014 IDLE: sig_grant=0; if any sig_request bit set, SHALL register grant to the round-robin winner and enter GRANTED (grant visible 1 cycle after request sampled).
REQ-015 Round-robin search SHALL start at index (last_winner+1) mod NUM_MASTERS and wrap; last_winner updates on every grant.
REQ-016 GRANTED: sig_start=1 SHALL enter XFER; owner's request dropping, or START_TIMEOUT cycles without sig_start, SHALL release to IDLE.
REQ-017 XFER: a data phase completes on a cycle with sig_wait=0; with sig_bip=1 SHALL remain in XFER, with sig_bip=0 SHALL release to IDLE.
REQ-018 Owner's sig_request dropping during XFER SHALL NOT release the grant; the transfer runs to completion.
REQ-019 Wait counter SHALL count consecutive sig_wait=1 cycles in XFER, clear on sig_wait=0, saturate never beyond WAIT_TIMEOUT.
REQ-020 When the wait counter reaches WAIT_TIMEOUT, SHALL pulse sig_error for exactly one cycle and release to IDLE in that same cycle.
REQ-021 Release SHALL drive sig_grant=0 for at least one cycle (IDLE) before any new grant (bus turnaround).
REQ-022 sig_grant SHALL never have more than one bit set; grant_id SHALL always match the set bit.
REQ-023 Requests from non-owners SHALL be ignored outside IDLE; no pre-emption.
REQ-024 START_TIMEOUT counter SHALL clear on entry to GRANTED.

Reset
REQ-025 sig_reset=0 at a rising edge SHALL force IDLE, sig_grant=0, grant_id=0, sig_error=0, counters=0, last_winner=NUM_MASTERS-1 (master 0 highest priority first).
REQ-026 Reset during GRANTED or XFER SHALL abort the tenure immediately with no sig_error pulse.

Structure
REQ-027 FSM state enum, default timeout constants and NUM_MASTERS default SHALL reside in shared package peripheral_bus_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module peripheral_rr_picker (inputs request, last_winner; outputs one-hot winner, index, valid).

Verification
REQ-029 Reset, then request=16'h0001 -> grant=16'h0001 next cycle, grant_id=0; sig_start, one phase wait=0 bip=0 -> grant=0 following cycle.
REQ-030 request=16'h8001 held, each owner does a single transfer -> grants alternate 0x0001, 0x8000, 0x0001 with one zero-grant cycle between.
REQ-031 Owner burst: start then bip=1 for 3 phases, wait=1 for 2 cycles mid-burst, last phase bip=0 -> grant held throughout, released after final phase, sig_error never set.
REQ-032 Grant to master 3, no sig_start for 4 cycles -> grant released, next requester (e.g. master 5) granted after one idle cycle.
REQ-033 In XFER hold sig_wait=1 for 16 cycles -> sig_error high exactly one cycle on the 16th, grant=0 next cycle.
REQ-034 Assert sig_reset=0 mid-burst -> grant=0, grant_id=0, no sig_error; after release, request=16'h0004 granted first.
